// File: rtl/stereo_ms_proc_if.sv
// Granule RAM and stage-control bundle for the stereo stage.
//   master : the stereo stage. It drives the RAM addresses, write strobes and
//            data, and stage_done. It receives the read data, header fields,
//            ms_bound and stage_ready.
//   slave  : the environment. This is the RAMs and the frame sequencer.
interface stereo_ms_proc_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] granule_ch0_read_addr;
  logic [DATA_W-1:0] granule_ch0_read_data;
  logic              granule_ch0_write_enable;
  logic [ADDR_W-1:0] granule_ch0_write_addr;
  logic [DATA_W-1:0] granule_ch0_write_data;
  logic [ADDR_W-1:0] granule_ch1_read_addr;
  logic [DATA_W-1:0] granule_ch1_read_data;
  logic              granule_ch1_write_enable;
  logic [ADDR_W-1:0] granule_ch1_write_addr;
  logic [DATA_W-1:0] granule_ch1_write_data;
  logic [1:0]        header_mode;
  logic [1:0]        header_mode_extension;
  logic [ADDR_W:0]   ms_bound;
  logic              stage_ready;
  logic              stage_done;

  modport master (
    output granule_ch0_read_addr, granule_ch0_write_enable,
           granule_ch0_write_addr, granule_ch0_write_data,
           granule_ch1_read_addr, granule_ch1_write_enable,
           granule_ch1_write_addr, granule_ch1_write_data,
           stage_done,
    input  granule_ch0_read_data, granule_ch1_read_data,
           header_mode, header_mode_extension, ms_bound, stage_ready
  );

  modport slave (
    input  granule_ch0_read_addr, granule_ch0_write_enable,
           granule_ch0_write_addr, granule_ch0_write_data,
           granule_ch1_read_addr, granule_ch1_write_enable,
           granule_ch1_write_addr, granule_ch1_write_data,
           stage_done,
    output granule_ch0_read_data, granule_ch1_read_data,
           header_mode, header_mode_extension, ms_bound, stage_ready
  );
endinterface

// File: rtl/stereo_ms_proc.sv
// MP3 mid/side stereo stage.
// The stage sweeps both granule channel RAMs. In joint stereo with MS enabled
// it rewrites each line below ms_bound in place:
//   ch0 = (L+R)/sqrt2
//   ch1 = (L-R)/sqrt2
// Results are saturated. Every other mode finishes without any RAM write.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : RAM read/write ports of both channels, the header fields,
//              ms_bound, stage_ready and stage_done (stereo_ms_proc_if.master)
//
// state  | meaning
// IDLE   | waiting for stage_ready; captures the MS condition and the bound
// SWEEP  | issuing one read per cycle for lines 0..NUM_LINES-1
// DRAIN  | waiting for the last reads to leave the pipeline
// DONE   | stage_done high for this single cycle
module stereo_ms_proc #(
  parameter int               DATA_W    = 18,
  parameter int               FRAC_W    = 16,
  parameter int               ADDR_W    = 10,
  parameter int               NUM_LINES = 576,
  parameter int               RD_LAT    = 1,
  parameter logic [DATA_W-1:0] K        = 18'h0B504
) (
  input logic              clk,
  input logic              rst,
  stereo_ms_proc_if.master bus
);

  localparam int P_W = 2*DATA_W + 1;
  localparam logic [ADDR_W:0]   LINES_W   = (ADDR_W+1)'(NUM_LINES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LINES - 1);
  localparam logic signed [P_W-1:0] SAT_MAX = P_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam logic signed [P_W-1:0] SAT_MIN = -SAT_MAX - P_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]   bound_q, bound_d;
  logic              done_q, done_d;
  logic              issue;

  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] addr_pipe_q [RD_LAT];

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr0_q, wr1_q;
  logic [DATA_W-1:0] sum_sat, diff_sat;

  // The IS flag in extension bit 0 is consumed by a different stage.
  logic unused_ext0;
  assign unused_ext0 = bus.header_mode_extension[0];

  // Scales by K in Q.FRAC_W. The arithmetic shift truncates toward -inf.
  // The result is then clamped to the DATA_W signed range.
  function automatic logic [DATA_W-1:0] scale_sat(input logic signed [DATA_W:0] x);
    logic signed [P_W-1:0] p;
    logic signed [P_W-1:0] sh;
    p  = P_W'(x) * P_W'($signed(K));
    sh = p >>> FRAC_W;
    if (sh > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (sh < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                   return sh[DATA_W-1:0];
  endfunction

  always_comb begin
    logic signed [DATA_W:0] a, b;
    a        = (DATA_W+1)'($signed(bus.granule_ch0_read_data));
    b        = (DATA_W+1)'($signed(bus.granule_ch1_read_data));
    sum_sat  = scale_sat(a + b);
    diff_sat = scale_sat(a - b);
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    bound_d   = bound_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.stage_ready) begin
          bound_d = (bus.ms_bound > LINES_W) ? LINES_W : bus.ms_bound;
          if (bus.header_mode == 2'b01 && bus.header_mode_extension[1]) begin
            state_d = S_SWEEP;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_SWEEP: begin
        issue = 1'b1;
        if (rd_addr_q == LAST_ADDR) begin
          rd_addr_d = '0;
          state_d   = S_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (vld_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The last pipeline stage carries the line whose read data is on the bus now.
  assign wr_en_d = vld_q[RD_LAT-1] && ({1'b0, addr_pipe_q[RD_LAT-1]} < bound_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      bound_q   <= '0;
      done_q    <= 1'b0;
      vld_q     <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_pipe_q[i] <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr0_q     <= '0;
      wr1_q     <= '0;
    end else begin
      state_q        <= state_d;
      rd_addr_q      <= rd_addr_d;
      bound_q        <= bound_d;
      done_q         <= done_d;
      vld_q[0]       <= issue;
      addr_pipe_q[0] <= rd_addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]       <= vld_q[i-1];
        addr_pipe_q[i] <= addr_pipe_q[i-1];
      end
      wr_en_q   <= wr_en_d;
      wr_addr_q <= addr_pipe_q[RD_LAT-1];
      wr0_q     <= sum_sat;
      wr1_q     <= diff_sat;
    end
  end

  assign bus.granule_ch0_read_addr    = rd_addr_q;
  assign bus.granule_ch1_read_addr    = rd_addr_q;
  assign bus.granule_ch0_write_enable = wr_en_q;
  assign bus.granule_ch1_write_enable = wr_en_q;
  assign bus.granule_ch0_write_addr   = wr_addr_q;
  assign bus.granule_ch1_write_addr   = wr_addr_q;
  assign bus.granule_ch0_write_data   = wr0_q;
  assign bus.granule_ch1_write_data   = wr1_q;
  assign bus.stage_done               = done_q;

endmodule
